// File: rtl/sd_cmd_tx_if.sv
// Command-path bundle between the SD host FSM and the CMD-line transmitter.
interface sd_cmd_tx_if;
    logic        bit_en;
    logic        start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_out;
    logic        cmd_oe;
    logic        busy;
    logic        done;
    logic [6:0]  crc_dbg;

    modport master (
        output bit_en, start, cmd_index, cmd_arg,
        input  cmd_out, cmd_oe, busy, done, crc_dbg
    );
    modport slave (
        input  bit_en, start, cmd_index, cmd_arg,
        output cmd_out, cmd_oe, busy, done, crc_dbg
    );
endinterface

// File: rtl/sd_cmd_tx.sv
// Serialises a 48-bit SD command frame MSB first on the CMD line, appending a
// serially computed CRC7 and TAIL_BITS idle-high bits before releasing the pad.
module sd_cmd_tx #(
    parameter int unsigned TAIL_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    sd_cmd_tx_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ARM, BODY, CRC, END, TAIL} state_t;

    state_t      state, state_n;
    logic [5:0]  cnt, cnt_n;
    logic [39:0] sr, sr_n;
    logic [6:0]  crc, crc_n;
    logic        out_q, out_n;
    logic        oe_q, oe_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;

    function automatic logic [6:0] crc_step(input logic [6:0] c, input logic d);
        logic fb;
        fb = c[6] ^ d;
        return {c[5:0], fb} ^ {3'b000, fb, 3'b000};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sr     <= '0;
            crc    <= '0;
            out_q  <= 1'b1;
            oe_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            sr     <= sr_n;
            crc    <= crc_n;
            out_q  <= out_n;
            oe_q   <= oe_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        crc_n   = crc;
        out_n   = out_q;
        oe_n    = oe_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                sr_n    = {2'b01, bus.cmd_index, bus.cmd_arg};
                crc_n   = '0;
                busy_n  = 1'b1;
                state_n = ARM;
            end
            ARM: if (bus.bit_en) begin
                oe_n    = 1'b1;
                out_n   = sr[39];
                crc_n   = crc_step(crc, sr[39]);
                sr_n    = {sr[38:0], 1'b0};
                cnt_n   = 6'd38;
                state_n = BODY;
            end
            BODY: if (bus.bit_en) begin
                out_n = sr[39];
                crc_n = crc_step(crc, sr[39]);
                sr_n  = {sr[38:0], 1'b0};
                if (cnt == 6'd0) begin
                    cnt_n   = 6'd6;
                    state_n = CRC;
                end else begin
                    cnt_n = cnt - 6'd1;
                end
            end
            CRC: if (bus.bit_en) begin
                out_n = crc[cnt[2:0]];
                if (cnt == 6'd0) state_n = END;
                else             cnt_n   = cnt - 6'd1;
            end
            END: if (bus.bit_en) begin
                // TAIL runs TAIL_BITS+1 strobes: one per idle slot plus the
                // strobe that closes the last driven slot (end bit when 0).
                out_n   = 1'b1;
                cnt_n   = 6'(TAIL_BITS);
                state_n = TAIL;
            end
            TAIL: if (bus.bit_en) begin
                out_n = 1'b1;
                if (cnt == 6'd0) begin
                    oe_n    = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 6'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.cmd_out = out_q;
    assign bus.cmd_oe  = oe_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.crc_dbg = crc;
endmodule

// File: tb/tb_sd_cmd_tx.sv
// Randomised self-checking bench for sd_cmd_tx (default tail and zero-tail builds).
module tb_sd_cmd_tx;
    localparam int TAIL = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sd_cmd_tx_if ia ();
    sd_cmd_tx_if ib ();

    sd_cmd_tx #(.TAIL_BITS(TAIL)) dut (.clk(clk), .rst(rst), .bus(ia));
    sd_cmd_tx #(.TAIL_BITS(0))    dut0 (.clk(clk), .rst(rst), .bus(ib));

    int total = 0;
    int bad   = 0;

    logic cap_bits[$];
    int   cap_done_s, cap_done_cnt, cap_hold_err, cap_busy_err;
    logic cap_busy_at_done;
    bit   cap_to;

    // Reference CRC by polynomial long division of msg*x^7 by x^7+x^3+1.
    function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        return r[6:0];
    endfunction

    function automatic logic [47:0] frame_ref(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b01, idx, arg};
        return {m, crc7_ref(m), 1'b1};
    endfunction

    function automatic logic [47:0] pack48(input logic q[$]);
        logic [47:0] v;
        v = '0;
        for (int i = 0; i < 48 && i < q.size(); i++) v = {v[46:0], q[i]};
        return v;
    endfunction

    function automatic int tail_ones(input logic q[$]);
        int n;
        n = 0;
        for (int i = 48; i < q.size(); i++) if (q[i] === 1'b1) n++;
        return n;
    endfunction

    // spacing: 0 = bit_en tied high, >0 = one strobe every N clks, <0 = random.
    task automatic send(input logic [5:0] idx, input logic [31:0] arg, input int spacing, input bit mid);
        int s, post;
        bit en, seen;
        logic po, poe;
        cap_bits.delete();
        cap_done_s = 0; cap_done_cnt = 0; cap_hold_err = 0; cap_busy_err = 0;
        cap_busy_at_done = 1'bx;
        @(negedge clk);
        ia.start = 1'b1; ia.cmd_index = idx; ia.cmd_arg = arg; ia.bit_en = 1'b0;
        @(posedge clk); @(negedge clk);
        ia.start = 1'b0;
        po = ia.cmd_out; poe = ia.cmd_oe;
        s = 0; post = 0; seen = 0;
        for (int n = 0; n < 3000; n++) begin
            if (spacing == 0)     en = 1'b1;
            else if (spacing > 0) en = ((n % spacing) == spacing - 1);
            else                  en = ($urandom_range(0, 2) == 0);
            ia.bit_en = en;
            if (mid && s == 10) begin ia.start = 1'b1; ia.cmd_index = 6'd55; ia.cmd_arg = $urandom; end
            if (mid && s >= 12) ia.start = 1'b0;
            @(posedge clk); @(negedge clk);
            if (en) begin
                s++;
                if (ia.cmd_oe === 1'b1) cap_bits.push_back(ia.cmd_out);
            end else if (ia.cmd_out !== po || ia.cmd_oe !== poe) begin
                cap_hold_err++;
            end
            if (ia.done === 1'b1) begin
                cap_done_cnt++;
                if (!seen) begin cap_done_s = s; cap_busy_at_done = ia.busy; end
                seen = 1;
            end else if (!seen && ia.busy !== 1'b1) begin
                cap_busy_err++;
            end
            po = ia.cmd_out; poe = ia.cmd_oe;
            if (seen) post++;
            if (post == 5) break;
        end
        ia.bit_en = 1'b0;
        ia.start  = 1'b0;
        cap_to = !seen;
    endtask

    task automatic check_frame(input string nm, input logic [47:0] exp, input int strobes_exp);
        logic [47:0] got;
        total++;
        if (cap_to) begin bad++; $display("FAIL %s timeout: no done seen", nm); end
        got = pack48(cap_bits);
        total++;
        if (got !== exp) begin bad++; $display("FAIL %s stream got=%h exp=%h", nm, got, exp); end
        total++;
        if (cap_bits.size() != 48 + TAIL) begin bad++; $display("FAIL %s oe_strobes got=%0d exp=%0d", nm, cap_bits.size(), 48 + TAIL); end
        total++;
        if (tail_ones(cap_bits) != TAIL) begin bad++; $display("FAIL %s tail_ones got=%0d exp=%0d", nm, tail_ones(cap_bits), TAIL); end
        total++;
        if (cap_done_s != strobes_exp) begin bad++; $display("FAIL %s done_strobe got=%0d exp=%0d", nm, cap_done_s, strobes_exp); end
        total++;
        if (cap_done_cnt != 1) begin bad++; $display("FAIL %s done_pulses got=%0d exp=1", nm, cap_done_cnt); end
        total++;
        if (cap_busy_err != 0 || cap_busy_at_done !== 1'b0) begin
            bad++; $display("FAIL %s busy drops=%0d busy_at_done=%b exp 0/0", nm, cap_busy_err, cap_busy_at_done);
        end
        total++;
        if (cap_hold_err != 0) begin bad++; $display("FAIL %s change_between_strobes got=%0d exp=0", nm, cap_hold_err); end
    endtask

    task automatic check_crc(input string nm, input logic [6:0] exp);
        total++;
        if (ia.crc_dbg !== exp) begin bad++; $display("FAIL %s crc_dbg got=%h exp=%h", nm, ia.crc_dbg, exp); end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (ia.cmd_out !== 1'b1 || ia.cmd_oe !== 1'b0 || ia.busy !== 1'b0 || ia.done !== 1'b0 || ia.crc_dbg !== 7'd0) begin
            bad++; $display("FAIL reset_values got out=%b oe=%b busy=%b done=%b crc=%h exp 1/0/0/0/00",
                            ia.cmd_out, ia.cmd_oe, ia.busy, ia.done, ia.crc_dbg);
        end
        @(negedge clk); rst = 1'b0; ia.bit_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); ia.bit_en = 1'b0;
        total++;
        if (ia.cmd_oe !== 1'b0 || ia.busy !== 1'b0 || ia.cmd_out !== 1'b1) begin
            bad++; $display("FAIL reset_release got oe=%b busy=%b out=%b exp 0/0/1", ia.cmd_oe, ia.busy, ia.cmd_out);
        end
    endtask

    task automatic test_cmd0();
        send(6'd0, 32'd0, 0, 0);
        check_frame("cmd0", 48'h400000000095, 49 + TAIL);
        check_crc("cmd0", 7'h4A);
    endtask

    task automatic test_cmd8();
        send(6'd8, 32'h000001AA, 4, 0);
        check_frame("cmd8", 48'h48000001AA87, 49 + TAIL);
        check_crc("cmd8", 7'h43);
    endtask

    task automatic test_cmd17_busy();
        send(6'd17, 32'd0, 3, 1);
        check_frame("cmd17", 48'h510000000055, 49 + TAIL);
        check_crc("cmd17", 7'h2A);
    endtask

    task automatic test_random();
        logic [5:0]  idx;
        logic [31:0] arg;
        for (int k = 0; k < 6; k++) begin
            idx = 6'($urandom);
            arg = $urandom;
            send(idx, arg, (k % 2 == 0) ? -1 : int'($urandom_range(1, 5)), k[0]);
            check_frame($sformatf("rand%0d", k), frame_ref(idx, arg), 49 + TAIL);
            check_crc($sformatf("rand%0d", k), crc7_ref({2'b01, idx, arg}));
        end
    endtask

    task automatic test_back_to_back();
        logic q0[$], q1[$];
        logic [5:0]  idx;
        logic [31:0] arg;
        int dones, gap_err;
        bit pend;
        idx = 6'($urandom); arg = $urandom;
        dones = 0; gap_err = 0; pend = 0;
        @(negedge clk);
        ia.start = 1'b1; ia.cmd_index = idx; ia.cmd_arg = arg; ia.bit_en = 1'b1;
        for (int n = 0; n < 400 && dones < 2; n++) begin
            @(posedge clk); @(negedge clk);
            if (pend) begin
                if (ia.busy !== 1'b1) gap_err++;
                pend = 0;
            end
            if (ia.cmd_oe === 1'b1) begin
                if (dones == 0) q0.push_back(ia.cmd_out);
                else            q1.push_back(ia.cmd_out);
            end
            if (ia.done === 1'b1) begin
                dones++;
                pend = (dones == 1);
                if (dones == 2) ia.start = 1'b0;
            end
        end
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            if (ia.done === 1'b1) dones++;
        end
        ia.bit_en = 1'b0;
        total++;
        if (dones != 2) begin bad++; $display("FAIL b2b done_pulses got=%0d exp=2", dones); end
        total++;
        if (gap_err != 0) begin bad++; $display("FAIL b2b restart got busy_low_after_done=%0d exp=0", gap_err); end
        total++;
        if (pack48(q0) !== frame_ref(idx, arg) || q0.size() != 48 + TAIL) begin
            bad++; $display("FAIL b2b frame1 got=%h n=%0d exp=%h n=%0d", pack48(q0), q0.size(), frame_ref(idx, arg), 48 + TAIL);
        end
        total++;
        if (pack48(q1) !== frame_ref(idx, arg) || q1.size() != 48 + TAIL) begin
            bad++; $display("FAIL b2b frame2 got=%h n=%0d exp=%h n=%0d", pack48(q1), q1.size(), frame_ref(idx, arg), 48 + TAIL);
        end
    endtask

    task automatic test_reset_midframe();
        logic [5:0]  idx;
        logic [31:0] arg;
        @(negedge clk);
        ia.start = 1'b1; ia.cmd_index = 6'($urandom); ia.cmd_arg = $urandom; ia.bit_en = 1'b0;
        @(posedge clk); @(negedge clk);
        ia.start = 1'b0; ia.bit_en = 1'b1;
        repeat (43) @(posedge clk);
        @(negedge clk);
        total++;
        if (ia.cmd_oe !== 1'b1 || ia.busy !== 1'b1) begin
            bad++; $display("FAIL rst_mid in_frame got oe=%b busy=%b exp 1/1", ia.cmd_oe, ia.busy);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (ia.cmd_oe !== 1'b0 || ia.cmd_out !== 1'b1 || ia.busy !== 1'b0 || ia.done !== 1'b0 || ia.crc_dbg !== 7'd0) begin
            bad++; $display("FAIL rst_mid async got oe=%b out=%b busy=%b done=%b crc=%h exp 0/1/0/0/00",
                            ia.cmd_oe, ia.cmd_out, ia.busy, ia.done, ia.crc_dbg);
        end
        @(negedge clk); rst = 1'b0; ia.bit_en = 1'b0;
        idx = 6'($urandom); arg = $urandom;
        send(idx, arg, 2, 0);
        check_frame("after_rst", frame_ref(idx, arg), 49 + TAIL);
    endtask

    task automatic test_tail0();
        logic q[$];
        int s, done_s;
        logic oe_at_done;
        done_s = -1; oe_at_done = 1'bx; s = 0;
        @(negedge clk);
        ib.start = 1'b1; ib.cmd_index = 6'd0; ib.cmd_arg = 32'd0; ib.bit_en = 1'b1;
        @(posedge clk); @(negedge clk);
        ib.start = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); @(negedge clk);
            s++;
            if (ib.cmd_oe === 1'b1) q.push_back(ib.cmd_out);
            if (ib.done === 1'b1) begin done_s = s; oe_at_done = ib.cmd_oe; break; end
        end
        ib.bit_en = 1'b0;
        total++;
        if (pack48(q) !== 48'h400000000095 || q.size() != 48) begin
            bad++; $display("FAIL tail0 stream got=%h n=%0d exp=400000000095 n=48", pack48(q), q.size());
        end
        total++;
        if (done_s != 49 || oe_at_done !== 1'b0) begin
            bad++; $display("FAIL tail0 done got strobe=%0d oe=%b exp 49/0", done_s, oe_at_done);
        end
        total++;
        if (ib.crc_dbg !== 7'h4A) begin bad++; $display("FAIL tail0 crc_dbg got=%h exp=4a", ib.crc_dbg); end
    endtask

    initial begin
        ia.start = 1'b0; ia.bit_en = 1'b0; ia.cmd_index = '0; ia.cmd_arg = '0;
        ib.start = 1'b0; ib.bit_en = 1'b0; ib.cmd_index = '0; ib.cmd_arg = '0;
        test_reset();
        test_cmd0();
        test_cmd8();
        test_cmd17_busy();
        test_random();
        test_back_to_back();
        test_reset_midframe();
        test_tail0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
